// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg: operation codes, FSM encodings and latencies
// shared by the fixed-point math core and its divider.
package fixed_point_pkg;

    localparam int FP_INT_W  = 8;
    localparam int FP_FRAC_W = 8;
    localparam int FP_N      = FP_INT_W + FP_FRAC_W;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // cycles from accepted start to done rising
    localparam int LAT_ADD = 1;
    localparam int LAT_MUL = FP_N + 1;
    localparam int LAT_DIV = FP_N + FP_FRAC_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADD      = 3'd1,
        ST_SUB      = 3'd2,
        ST_MUL_RUN  = 3'd3,
        ST_DIV_RUN  = 3'd4,
        ST_FIX_SIGN = 3'd5
    } state_e;

endpackage

// File: rtl/fixed_point_serial_divider.sv
// fixed_point_serial_divider: restoring unsigned divider producing one
// quotient bit per cycle; asserts last on its final step.
module fixed_point_serial_divider
    import fixed_point_pkg::*;
#(
    parameter int N = FP_N,
    parameter int F = FP_FRAC_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [N+F-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           last,
    output logic [N-1:0]   quotient
);

    localparam int QW = N + F;
    localparam int CW = $clog2(QW);

    logic [QW-1:0] quo_q, quo_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;
    logic [N:0]    rem_sh;
    logic [N+1:0]  diff;

    // one restore step per cycle: shift in a dividend bit, try subtract
    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        rem_sh = {rem_q, quo_q[QW-1]};
        diff   = {1'b0, rem_sh} - {2'b00, dvs_q};
        if (load) begin
            quo_d = dividend;
            rem_d = '0;
            dvs_d = divisor;
            cnt_d = CW'(QW - 1);
            run_d = 1'b1;
        end else if (run_q) begin
            if (!diff[N+1]) begin
                rem_d = diff[N-1:0];
                quo_d = {quo_q[QW-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[N-1:0];
                quo_d = {quo_q[QW-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end
        end
    end

    // divider state registers; reset abandons any division in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign last     = run_q && (cnt_q == '0);
    assign quotient = quo_q[N-1:0];

endmodule

// File: rtl/fixed_point_math_core.sv
// fixed_point_math_core: signed QI.F add/sub (1 cycle), serial mul and
// restoring div behind one start/done handshake.
module fixed_point_math_core
    import fixed_point_pkg::*;
#(
    parameter int INTEGER_PART_WIDTH    = FP_INT_W,
    parameter int FRACTIONAL_PART_WIDTH = FP_FRAC_W
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic [1:0] op,
    input  logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] a,
    input  logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] b,
    output logic done,
    output logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] result
);

    localparam int N   = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH;
    localparam int F   = FRACTIONAL_PART_WIDTH;
    localparam int MCW = $clog2(N);

    state_e state_q, state_d;

    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [2*N-1:0] prod_q, prod_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [MCW-1:0] mcnt_q, mcnt_d;
    logic           neg_q, neg_d;
    logic           a_neg_q, a_neg_d;
    logic           bz_q, bz_d;
    logic           is_div_q, is_div_d;
    logic [N-1:0]   result_q, result_d;

    logic           launch;
    logic           div_load;
    logic           div_last;
    logic [N-1:0]   mag_a;
    logic [N-1:0]   mag_b;
    logic [N-1:0]   div_quot;
    logic [N-1:0]   mul_mag;

    // most-negative input maps to 2^(N-1), which fits N unsigned bits
    assign mag_a   = a[N-1] ? (~a + 1'b1) : a;
    assign mag_b   = b[N-1] ? (~b + 1'b1) : b;
    assign mul_mag = prod_q[F +: N];

    fixed_point_serial_divider #(
        .N (N),
        .F (F)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .dividend ({mag_a, {F{1'b0}}}),
        .divisor  (mag_b),
        .last     (div_last),
        .quotient (div_quot)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: dispatch on op, serial ops finish via FIX_SIGN
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_ADD:  state_d = ST_ADD;
                        OP_SUB:  state_d = ST_SUB;
                        OP_MUL:  state_d = ST_MUL_RUN;
                        default: state_d = ST_DIV_RUN;
                    endcase
                end
            end
            ST_ADD, ST_SUB: state_d = ST_IDLE;
            ST_MUL_RUN: begin
                if (mcnt_q == '0) begin
                    state_d = ST_FIX_SIGN;
                end
            end
            ST_DIV_RUN: begin
                if (div_last) begin
                    state_d = ST_FIX_SIGN;
                end
            end
            ST_FIX_SIGN: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: idle means done, start only accepted while idle
    always_comb begin
        done     = (state_q == ST_IDLE);
        launch   = done && start;
        div_load = launch && (op == OP_DIV);
    end

    // datapath: operand capture, shift-add steps and result write
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        mcnt_d   = mcnt_q;
        neg_d    = neg_q;
        a_neg_d  = a_neg_q;
        bz_d     = bz_q;
        is_div_d = is_div_q;
        result_d = result_q;
        if (launch) begin
            a_d      = a;
            b_d      = b;
            prod_d   = '0;
            mcand_d  = {{N{1'b0}}, mag_a};
            mplier_d = mag_b;
            mcnt_d   = MCW'(N - 1);
            neg_d    = a[N-1] ^ b[N-1];
            a_neg_d  = a[N-1];
            bz_d     = (b == '0);
            is_div_d = (op == OP_DIV);
        end
        case (state_q)
            ST_ADD: result_d = a_q + b_q;
            ST_SUB: result_d = a_q - b_q;
            ST_MUL_RUN: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                mcnt_d   = mcnt_q - 1'b1;
            end
            ST_FIX_SIGN: begin
                if (is_div_q) begin
                    if (bz_q) begin
                        result_d = a_neg_q ? {1'b1, {(N-1){1'b0}}}
                                           : {1'b0, {(N-1){1'b1}}};
                    end else begin
                        result_d = neg_q ? (~div_quot + 1'b1) : div_quot;
                    end
                end else begin
                    result_d = neg_q ? (~mul_mag + 1'b1) : mul_mag;
                end
            end
            default: ;
        endcase
    end

    // datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            mcnt_q   <= '0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            bz_q     <= 1'b0;
            is_div_q <= 1'b0;
            result_q <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            mcnt_q   <= mcnt_d;
            neg_q    <= neg_d;
            a_neg_q  <= a_neg_d;
            bz_q     <= bz_d;
            is_div_q <= is_div_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_fixed_point_math_core.sv
// tb_fixed_point_math_core: directed and random ops on the Q8.8 core,
// checked against a plain-arithmetic reference model.
module tb_fixed_point_math_core;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        done;
    logic [15:0] result;

    int n_run;
    int n_fail;

    typedef struct {
        logic [1:0]  o;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] r;
        int          l;
    } vec_t;

    vec_t vecs [0:7];

    fixed_point_math_core dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .done   (done),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] o);
        if (o == 2'd2) return 17;
        if (o == 2'd3) return 25;
        return 1;
    endfunction

    // reference: signed real-valued arithmetic on Q8.8, wrapped to 16 bits
    function automatic logic [15:0] model(input logic [1:0] o,
                                          input logic [15:0] x,
                                          input logic [15:0] y);
        longint ma;
        longint mb;
        longint m;
        bit     neg;
        ma = longint'(x);
        mb = longint'(y);
        if (x[15]) ma = 65536 - ma;
        if (y[15]) mb = 65536 - mb;
        neg = x[15] ^ y[15];
        m = 0;
        case (o)
            2'd0: m = longint'(x) + longint'(y);
            2'd1: m = longint'(x) - longint'(y);
            2'd2: begin
                m = (ma * mb) / 256;
                if (neg) m = -m;
            end
            default: begin
                if (y == 16'h0000) return x[15] ? 16'h8000 : 16'h7FFF;
                m = (ma * 256) / mb;
                if (neg) m = -m;
            end
        endcase
        return m[15:0];
    endfunction

    // launch one op, scramble operands afterwards, measure latency;
    // with poke set, random start pulses are thrown at the busy core
    task automatic run_op(input logic [1:0] o, input logic [15:0] x,
                          input logic [15:0] y, input bit poke,
                          output int lat);
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        lat   = 0;
        while (!done && lat < 100) begin
            if (poke) begin
                start = 1'($urandom_range(0, 1));
                op    = 2'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
    endtask

    function automatic logic [15:0] pick();
        logic [15:0] c [0:5];
        c[0] = 16'h0000;
        c[1] = 16'h8000;
        c[2] = 16'h7FFF;
        c[3] = 16'hFFFF;
        c[4] = 16'h0100;
        c[5] = 16'h0001;
        if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 5)];
        return 16'($urandom);
    endfunction

    initial begin
        int lat;
        logic [1:0]  ro;
        logic [15:0] rx;
        logic [15:0] ry;
        n_run  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        op     = 2'd0;
        a      = 16'h0000;
        b      = 16'h0000;

        vecs[0] = '{2'd0, 16'h0180, 16'h0240, 16'h03C0, 1};
        vecs[1] = '{2'd1, 16'h8000, 16'h0100, 16'h7F00, 1};
        vecs[2] = '{2'd2, 16'h0180, 16'hFE00, 16'hFD00, 17};
        vecs[3] = '{2'd2, 16'h1000, 16'h1000, 16'h0000, 17};
        vecs[4] = '{2'd3, 16'h0100, 16'h0300, 16'h0055, 25};
        vecs[5] = '{2'd3, 16'hF900, 16'h0200, 16'hFC80, 25};
        vecs[6] = '{2'd3, 16'h0100, 16'h0000, 16'h7FFF, 25};
        vecs[7] = '{2'd3, 16'hFF00, 16'h0000, 16'h8000, 25};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 32'(done), 32'd1);
        chk("rst_result", 32'(result), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_done", 32'(done), 32'd1);

        // abort a division with reset partway through
        @(negedge clk);
        op    = 2'd3;
        a     = 16'h0100;
        b     = 16'h0300;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("abort_busy", 32'(done), 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_done", 32'(done), 32'd1);
        chk("abort_result", 32'(result), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("abort_late_done", 32'(done), 32'd1);
        chk("abort_late_result", 32'(result), 32'h0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].o, vecs[i].x, vecs[i].y, 1'b0, lat);
            chk($sformatf("dir%0d_res", i), 32'(result), 32'(vecs[i].r));
            chk($sformatf("dir%0d_lat", i), 32'(lat), 32'(vecs[i].l));
        end

        // start pulses while busy must not disturb a running mul
        run_op(2'd2, 16'h0300, 16'h0200, 1'b1, lat);
        chk("busy_res", 32'(result), 32'h0600);
        chk("busy_lat", 32'(lat), 32'd17);
        run_op(2'd3, 16'hF900, 16'h0200, 1'b1, lat);
        chk("busy_div_res", 32'(result), 32'hFC80);
        chk("busy_div_lat", 32'(lat), 32'd25);

        // back-to-back: add, then mul with start held through done=1
        @(negedge clk);
        op    = 2'd0;
        a     = 16'h0180;
        b     = 16'h0240;
        start = 1'b1;
        @(posedge clk);
        #1;
        op = 2'd2;
        a  = 16'h0180;
        b  = 16'hFE00;
        chk("b2b_add_busy", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        chk("b2b_add_done", 32'(done), 32'd1);
        chk("b2b_add_res", 32'(result), 32'h03C0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_mul_busy", 32'(done), 32'd0);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("b2b_mul_res", 32'(result), 32'hFD00);
        chk("b2b_mul_lat", 32'(lat), 32'd17);

        for (int i = 0; i < 48; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = pick();
            ry = pick();
            run_op(ro, rx, ry, 1'($urandom_range(0, 1)), lat);
            chk($sformatf("rnd%0d_op%0d_%h_%h", i, ro, rx, ry),
                32'(result), 32'(model(ro, rx, ry)));
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(exp_lat(ro)));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
